// File: rtl/sa48_pkg.sv
// Shared definitions for the SA48 chunked adder interface: widths, driver states,
// operand payload and the chunk-select helper.
package sa48_pkg;

  localparam int unsigned CHUNK_W    = 12;
  localparam int unsigned NUM_CHUNKS = 4;
  localparam int unsigned WORD_W     = CHUNK_W * NUM_CHUNKS;
  localparam int unsigned IDX_W      = $clog2(NUM_CHUNKS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    SEND,
    WAIT_RES,
    HOLD
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
  } op_pair_t;

  // Chunk k of a word, chunk 0 being the least-significant CHUNK_W bits.
  function automatic logic [CHUNK_W-1:0] chunk_sel(input logic [WORD_W-1:0] word,
                                                   input logic [IDX_W-1:0]  k);
    return CHUNK_W'(word >> (32'(k) * CHUNK_W));
  endfunction

endpackage

// File: rtl/sa48_chunk_driver_if.sv
// Operand, adder-facing and result signals of the SA48 chunk driver.
interface sa48_chunk_driver_if;
  import sa48_pkg::*;

  logic               op_valid;
  logic               op_ready;
  logic [WORD_W-1:0]  op_a;
  logic [WORD_W-1:0]  op_b;
  logic               startChunks;
  logic [CHUNK_W-1:0] inBusA;
  logic [CHUNK_W-1:0] inBusB;
  logic               resultReady;
  logic [WORD_W-1:0]  outBus;
  logic               res_valid;
  logic               res_ready;
  logic [WORD_W-1:0]  res_data;
  logic               res_err;

  modport master (
    input  op_valid, op_a, op_b, resultReady, outBus, res_ready,
    output op_ready, startChunks, inBusA, inBusB, res_valid, res_data, res_err
  );

  modport slave (
    output op_valid, op_a, op_b, resultReady, outBus, res_ready,
    input  op_ready, startChunks, inBusA, inBusB, res_valid, res_data, res_err
  );

endinterface

// File: rtl/sa48_chunk_driver.sv
// Initiator for the SA48 adder: takes an operand pair, pulses startChunks, streams
// 12-bit chunks LS-first, then captures the sum (or a timeout) and holds it for the consumer.
module sa48_chunk_driver
  import sa48_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned RESULT_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  sa48_chunk_driver_if.master bus
);

  localparam int unsigned CNT_MAX = (RESULT_TIMEOUT > GAP_CYCLES) ? RESULT_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RESULT_TIMEOUT - 1);

  state_t             state, state_n;
  op_pair_t           ops, ops_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic               op_ready_q, op_ready_n;
  logic               start_q, start_n;
  logic [CHUNK_W-1:0] bus_a_q, bus_a_n;
  logic [CHUNK_W-1:0] bus_b_q, bus_b_n;
  logic               res_valid_q, res_valid_n;
  logic [WORD_W-1:0]  res_data_q, res_data_n;
  logic               res_err_q, res_err_n;

  // State, counters and every output are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ops         <= '0;
      idx         <= '0;
      cnt         <= '0;
      op_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      bus_a_q     <= '0;
      bus_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state       <= state_n;
      ops         <= ops_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      op_ready_q  <= op_ready_n;
      start_q     <= start_n;
      bus_a_q     <= bus_a_n;
      bus_b_q     <= bus_b_n;
      res_valid_q <= res_valid_n;
      res_data_q  <= res_data_n;
      res_err_q   <= res_err_n;
    end
  end

  // Next state; outputs are derived from the next state so they line up with it.
  always_comb begin
    state_n    = state;
    ops_n      = ops;
    idx_n      = idx;
    cnt_n      = cnt;
    res_data_n = res_data_q;
    res_err_n  = res_err_q;

    unique case (state)
      IDLE: begin
        if (bus.op_valid && op_ready_q) begin
          ops_n   = '{a: bus.op_a, b: bus.op_b};
          state_n = START;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = (GAP_CYCLES == 0) ? SEND : GAP;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = SEND;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SEND: begin
        if (idx == LAST_IDX) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = WAIT_RES;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      WAIT_RES: begin
        // A result arriving on the timeout cycle still counts as a result.
        if (bus.resultReady) begin
          res_data_n = bus.outBus;
          res_err_n  = 1'b0;
          cnt_n      = '0;
          state_n    = HOLD;
        end else if (cnt == TMO_LAST) begin
          res_data_n = '0;
          res_err_n  = 1'b1;
          cnt_n      = '0;
          state_n    = HOLD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    op_ready_n  = (state_n == IDLE);
    start_n     = (state_n == START);
    res_valid_n = (state_n == HOLD);
    bus_a_n     = (state_n == SEND) ? chunk_sel(ops_n.a, idx_n) : '0;
    bus_b_n     = (state_n == SEND) ? chunk_sel(ops_n.b, idx_n) : '0;
  end

  assign bus.op_ready    = op_ready_q;
  assign bus.startChunks = start_q;
  assign bus.inBusA      = bus_a_q;
  assign bus.inBusB      = bus_b_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_err     = res_err_q;

endmodule

// File: tb/tb_sa48_chunk_driver.sv
// Bench for sa48_chunk_driver: timeline model checked every cycle, a small adder
// responder, and directed transactions with hand-computed chunks, sums and latencies.
module tb_sa48_chunk_driver;
  import sa48_pkg::*;

  localparam int GAP      = 1;
  localparam int TMO      = 64;
  localparam int WAIT_OFS = 1 + GAP + int'(NUM_CHUNKS);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_en = 1'b0;

  sa48_chunk_driver_if bus();

  sa48_chunk_driver #(.GAP_CYCLES(GAP), .RESULT_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: a transaction accepted in cycle p starts at T=p+1; chunks follow
  // the gap; the wait window opens at T+WAIT_OFS and lasts TMO cycles.
  logic        m_busy, m_hold, m_err;
  int          m_t;
  logic [47:0] m_a, m_b, m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_hold <= 1'b0;
      m_err  <= 1'b0;
      m_res  <= '0;
      m_t    <= 0;
      m_a    <= '0;
      m_b    <= '0;
    end else if (!m_busy) begin
      if (bus.op_valid) begin
        m_busy <= 1'b1;
        m_t    <= cyc + 1;
        m_a    <= bus.op_a;
        m_b    <= bus.op_b;
      end
    end else if (m_hold) begin
      if (bus.res_ready) begin
        m_busy <= 1'b0;
        m_hold <= 1'b0;
      end
    end else if (cyc >= m_t + WAIT_OFS) begin
      if (bus.resultReady) begin
        m_hold <= 1'b1;
        m_res  <= bus.outBus;
        m_err  <= 1'b0;
      end else if (cyc == m_t + WAIT_OFS + TMO - 1) begin
        m_hold <= 1'b1;
        m_res  <= '0;
        m_err  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int k;
    logic [47:0] sa, sb;
    logic [11:0] ea, eb;
    if (chk_en) begin
      k  = cyc - m_t - 1 - GAP;
      ea = '0;
      eb = '0;
      if (m_busy && k >= 0 && k < int'(NUM_CHUNKS)) begin
        sa = m_a >> (12 * k);
        sb = m_b >> (12 * k);
        ea = sa[11:0];
        eb = sb[11:0];
      end
      check("op_ready",    48'(bus.op_ready),    48'(!m_busy));
      check("startChunks", 48'(bus.startChunks), 48'(m_busy && cyc == m_t));
      check("inBusA",      48'(bus.inBusA),      48'(ea));
      check("inBusB",      48'(bus.inBusB),      48'(eb));
      check("res_valid",   48'(bus.res_valid),   48'(m_hold));
      if (m_hold) begin
        check("res_data", bus.res_data, m_res);
        check("res_err",  48'(bus.res_err), 48'(m_err));
      end
    end
  end

  // Called at a negedge; returns at the negedge of the START cycle.
  task automatic offer(input logic [47:0] a, input logic [47:0] b);
    int n;
    n = 0;
    while (!bus.op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("offer_ready", 48'(bus.op_ready), 48'd1);
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  task automatic collect(input string name, output int t0,
                         output logic [3:0][11:0] ca, output logic [3:0][11:0] cb);
    int n;
    n = 0;
    while (!bus.startChunks && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_start"}, 48'(bus.startChunks), 48'd1);
    t0 = cyc;
    @(negedge clk);
    check({name, "_gap_a"}, 48'(bus.inBusA), 48'd0);
    check({name, "_gap_b"}, 48'(bus.inBusB), 48'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ca[i] = bus.inBusA;
      cb[i] = bus.inBusB;
    end
  endtask

  task automatic run_txn(input string name, input logic [47:0] a, input logic [47:0] b,
                         input logic [47:0] eca, input logic [47:0] ecb,
                         input int lat, input bit respond, input int hold, input bit junk,
                         input logic [47:0] edata, input bit eerr, input int elat);
    int t0;
    int n;
    logic [3:0][11:0] ca, cb;
    offer(a, b);
    collect(name, t0, ca, cb);
    check({name, "_chunks_a"}, 48'(ca), eca);
    check({name, "_chunks_b"}, 48'(cb), ecb);
    if (respond) begin
      repeat (lat) @(negedge clk);
      bus.outBus      = 48'(ca) + 48'(cb);
      bus.resultReady = 1'b1;
    end
    n = 0;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.resultReady = 1'b0;
    check({name, "_latency"}, 48'(cyc - t0), 48'(elat));
    check({name, "_data"}, bus.res_data, edata);
    check({name, "_err"}, 48'(bus.res_err), 48'(eerr));
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        bus.op_valid = 1'b1;
        bus.op_a     = 48'hFFF_FFF_FFF_FFF;
        bus.op_b     = 48'h123_456_789_ABC;
      end
      @(negedge clk);
      check({name, "_hold_valid"}, 48'(bus.res_valid), 48'd1);
      check({name, "_hold_ready"}, 48'(bus.op_ready), 48'd0);
      check({name, "_hold_data"}, bus.res_data, edata);
    end
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({name, "_post_ready"}, 48'(bus.op_ready), 48'd1);
    check({name, "_post_valid"}, 48'(bus.res_valid), 48'd0);
  endtask

  initial begin
    int n;
    bus.op_valid    = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.resultReady = 1'b0;
    bus.outBus      = '0;
    bus.res_ready   = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_op_ready",  48'(bus.op_ready),    48'd1);
    check("rst_start",     48'(bus.startChunks), 48'd0);
    check("rst_res_valid", 48'(bus.res_valid),   48'd0);
    check("rst_res_data",  bus.res_data,         48'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    run_txn("basic", 48'h004003002001, 48'h004003002001,
            {12'd4, 12'd3, 12'd2, 12'd1}, {12'd4, 12'd3, 12'd2, 12'd1},
            3, 1'b1, 0, 1'b0, 48'h008006004002, 1'b0, 9);

    // Result level raised during the last chunk is taken on the first wait cycle.
    run_txn("small", 48'd1, 48'd2,
            {12'd0, 12'd0, 12'd0, 12'd1}, {12'd0, 12'd0, 12'd0, 12'd2},
            0, 1'b1, 0, 1'b0, 48'd3, 1'b0, 7);

    // Chunk 1 sums 0x090 + 0x0FF = 0x18F with no carry in from chunk 0.
    run_txn("mixed", 48'h01312B090022, 48'h7D001D0FF042,
            {12'd19, 12'd299, 12'd144, 12'd34}, {12'd2000, 12'd29, 12'd255, 12'd66},
            1, 1'b1, 0, 1'b0, 48'h7E314818F064, 1'b0, 7);

    run_txn("bp", 48'h004003002001, 48'h004003002001,
            {12'd4, 12'd3, 12'd2, 12'd1}, {12'd4, 12'd3, 12'd2, 12'd1},
            2, 1'b1, 10, 1'b1, 48'h008006004002, 1'b0, 8);

    run_txn("tmo", 48'hABC_DEF_012_345, 48'h111_222_333_444,
            {12'hABC, 12'hDEF, 12'h012, 12'h345}, {12'h111, 12'h222, 12'h333, 12'h444},
            0, 1'b0, 2, 1'b0, 48'd0, 1'b1, 70);

    // Abort after chunk 1 of a transaction, then confirm recovery.
    offer(48'h0AB_0CD_0EF_012, 48'h0345_0678_09A);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_op_ready",  48'(bus.op_ready),    48'd1);
    check("abort_start",     48'(bus.startChunks), 48'd0);
    check("abort_bus_a",     48'(bus.inBusA),      48'd0);
    check("abort_bus_b",     48'(bus.inBusB),      48'd0);
    check("abort_res_valid", 48'(bus.res_valid),   48'd0);
    check("abort_res_data",  bus.res_data,         48'd0);
    check("abort_res_err",   48'(bus.res_err),     48'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.res_valid) n++;
    end
    check("abort_no_result", 48'(n), 48'd0);

    run_txn("after_rst", 48'h004003002001, 48'h004003002001,
            {12'd4, 12'd3, 12'd2, 12'd1}, {12'd4, 12'd3, 12'd2, 12'd1},
            1, 1'b1, 1, 1'b0, 48'h008006004002, 1'b0, 7);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
